// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronises and debounces a pushbutton, emitting press/release strobes and a press count.
module button_pulse_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 10,
  parameter int NBITS_DEB   = 8,
  parameter int NBITS_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   botao,
  output logic                   pulso,
  output logic                   solto,
  output logic                   estavel,
  output logic [NBITS_COUNT-1:0] press_count
);
  typedef enum logic [1:0] {SOLTO_EST, CONF_PRESS, PRESS_EST, CONF_SOLTO} state_t;
  localparam logic [NBITS_DEB-1:0] DEB_LAST = NBITS_DEB'(DEB_CYCLES - 1);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [NBITS_DEB-1:0] cnt, cnt_n;
  logic sync, done, pulso_n, solto_n;
  assign sync = sync_q[SYNC_STAGES-1];
  assign done = cnt == DEB_LAST;
  // Any opposite sample while confirming drops back to the stable state and discards progress.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    pulso_n = 1'b0;
    solto_n = 1'b0;
    case (state)
      SOLTO_EST: begin
        state_n = sync ? CONF_PRESS : SOLTO_EST;
        cnt_n   = NBITS_DEB'(sync);
      end
      CONF_PRESS:
        if (!sync) state_n = SOLTO_EST;
        else if (done) begin
          state_n = PRESS_EST;
          pulso_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      PRESS_EST: begin
        state_n = sync ? PRESS_EST : CONF_SOLTO;
        cnt_n   = NBITS_DEB'(!sync);
      end
      CONF_SOLTO:
        if (sync) state_n = PRESS_EST;
        else if (done) begin
          state_n = SOLTO_EST;
          solto_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      default: state_n = SOLTO_EST;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q      <= '0;
      state       <= SOLTO_EST;
      cnt         <= '0;
      pulso       <= 1'b0;
      solto       <= 1'b0;
      estavel     <= 1'b0;
      press_count <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], botao};
      state       <= state_n;
      cnt         <= cnt_n;
      pulso       <= pulso_n;
      solto       <= solto_n;
      estavel     <= state_n inside {PRESS_EST, CONF_SOLTO};
      press_count <= press_count + NBITS_COUNT'(pulso_n);
    end
endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen: segment table plus scoreboard of per-cycle expected outputs for button_pulse_gen.
module tb_button_pulse_gen;
  localparam int LAT = 11;
  typedef struct {logic b; int len; logic acc;} seg_t;
  typedef struct {logic p; logic s; logic e; logic [3:0] c;} exp_t;
  logic clk = 1'b0, reset = 1'b1, botao = 1'b0;
  logic pulso, solto, estavel;
  logic [3:0] press_count;
  int n_cmp = 0, n_err = 0, n_pulso = 0, n_solto = 0;
  logic est_m = 1'b0;
  logic [3:0] cnt_m = '0;
  exp_t sb[$];
  button_pulse_gen dut (
    .clk(clk), .reset(reset), .botao(botao),
    .pulso(pulso), .solto(solto), .estavel(estavel), .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask
  task automatic chk_zero(string nm);
    chk({nm, ".pulso"}, pulso, 0);
    chk({nm, ".solto"}, solto, 0);
    chk({nm, ".estavel"}, estavel, 0);
    chk({nm, ".press_count"}, press_count, 0);
  endtask
  task automatic step(logic b, exp_t e);
    exp_t x;
    @(negedge clk);
    botao = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("pulso", pulso, x.p);
    chk("solto", solto, x.s);
    chk("estavel", estavel, x.e);
    chk("press_count", press_count, x.c);
    n_pulso += int'(pulso);
    n_solto += int'(solto);
  endtask
  // Strobe lands on edge LAT of a segment whose level gets accepted.
  task automatic run_seg(seg_t g);
    exp_t e;
    for (int k = 0; k < g.len; k++) begin
      e.p = g.acc && g.b && k == LAT;
      e.s = g.acc && !g.b && k == LAT;
      e.e = (g.acc && k >= LAT) ? g.b : est_m;
      e.c = cnt_m + 4'((g.acc && g.b && k >= LAT) ? 1 : 0);
      step(g.b, e);
    end
    if (g.acc) begin
      est_m = g.b;
      if (g.b) cnt_m++;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    botao = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 reset = 1'b0;
    est_m = 1'b0;
    cnt_m = '0;
    n_pulso = 0;
    n_solto = 0;
  endtask
  initial begin
    seg_t tbl [13];
    tbl = '{
      '{1'b0, 50, 1'b0},
      '{1'b1, 20, 1'b1}, '{1'b0, 20, 1'b1},
      '{1'b1, 9, 1'b0}, '{1'b0, 1, 1'b0}, '{1'b1, 9, 1'b0}, '{1'b0, 1, 1'b0}, '{1'b1, 20, 1'b1},
      '{1'b0, 9, 1'b0}, '{1'b1, 1, 1'b0}, '{1'b0, 15, 1'b1},
      '{1'b1, 100, 1'b1}, '{1'b0, 15, 1'b1}
    };
    do_reset();
    foreach (tbl[i]) run_seg(tbl[i]);
    chk("table.pulses", 8'(n_pulso), 3);
    chk("table.releases", 8'(n_solto), 3);
    chk("table.press_count", press_count, 3);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_seg('{1'b1, 14, 1'b1});
      run_seg('{1'b0, 14, 1'b1});
    end
    chk("wrap.pulses", 8'(n_pulso), 17);
    chk("wrap.releases", 8'(n_solto), 17);
    chk("wrap.press_count", press_count, 1);
    do_reset();
    run_seg('{1'b1, 8, 1'b0});
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    repeat (3) begin
      @(posedge clk);
      #1 chk_zero("reset_hold");
    end
    #2 reset = 1'b0;
    run_seg('{1'b1, 20, 1'b1});
    chk("restart.pulses", 8'(n_pulso), 1);
    chk("restart.press_count", press_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/button_pulse_gen.md
Name: button_pulse_gen

Overview:
- Front-end conditioner for the board pushbuttons.
- Synchronises a raw, bouncing button input to clk and debounces it with a confirmation state machine.
- Emits exactly one single-cycle pulse per accepted press. That pulse is the restart strobe ("entrada") of the one-hot sequence counter directly downstream.
- Also provides the debounced level, a release pulse, and a wrapping count of accepted presses.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on botao; legal range 2..3.
- DEB_CYCLES, 10, consecutive identical synchronised samples required to accept a level change; legal range 2..255.
- NBITS_DEB, 8, width of the internal stability counter; must satisfy DEB_CYCLES <= 2**NBITS_DEB - 1.
- NBITS_COUNT, 4, width of press_count.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- botao  input  1  raw pushbutton level; asynchronous to clk and may bounce.
- pulso  output  1  one-cycle strobe on each accepted press; feeds the downstream counter's entrada.
- solto  output  1  one-cycle strobe on each accepted release.
- estavel  output  1  debounced button level.
- press_count  output  NBITS_COUNT  number of accepted presses, modulo 2**NBITS_COUNT.

Behaviour:
- Reset (asynchronous, active-high):
  - All synchroniser flops = 0; stability counter = 0; FSM = SOLTO_EST.
  - pulso = 0, solto = 0, estavel = 0, press_count = 0.
  - All values hold while reset is high.
- Synchroniser:
  - botao passes through SYNC_STAGES flops; the last flop is "sync".
  - Only sync is used by the FSM.
- Sample-to-output latency:
  - Let E0 be the first rising edge at which botao is sampled high. sync is first high after edge E(SYNC_STAGES-1).
  - Edges E(SYNC_STAGES) onward are the "samples" the FSM observes.
- FSM states:
  - SOLTO_EST: stable released, estavel = 0.
  - CONF_PRESS: confirming a press.
  - PRESS_EST: stable pressed, estavel = 1.
  - CONF_SOLTO: confirming a release.
- Transitions, evaluated each edge:
  - SOLTO_EST, sync = 1: go to CONF_PRESS, counter = 1.
  - SOLTO_EST, sync = 0: stay, counter = 0.
  - CONF_PRESS, sync = 0: return to SOLTO_EST, counter = 0, no output change.
  - CONF_PRESS, sync = 1, counter < DEB_CYCLES-1: counter++.
  - CONF_PRESS, sync = 1, counter = DEB_CYCLES-1: go to PRESS_EST, counter = 0. Registered together on this edge: estavel <= 1, pulso <= 1, press_count <= press_count + 1.
  - PRESS_EST and CONF_SOLTO mirror the two states above with sync inverted. On completion: estavel <= 0, solto <= 1. press_count is unchanged.
- Press timing:
  - A press is accepted on the DEB_CYCLES-th consecutive high sample.
  - With defaults: pulso and estavel are high after edge E11; pulso returns low after E12.
- Strobe rules:
  - pulso and solto are registered and high for exactly one clk cycle.
  - pulso and solto are never high in the same cycle.
  - No further pulso occurs until a release has been accepted (estavel has fallen).
- Bounce:
  - Any opposite sample during confirmation discards progress.
  - A run of DEB_CYCLES-1 samples followed by one opposite sample produces no output change.
- press_count wraps from 2**NBITS_COUNT-1 to 0 with no flag.
- Reset mid-operation:
  - A press in progress is aborted and no pulse is emitted.
  - If botao is still held after reset deasserts, the press is treated as new: a full SYNC_STAGES + DEB_CYCLES delay applies, then pulso.
- No combinational path from botao to any output.

Test Plan:
- Reset, then botao held 0 for 50 cycles -> pulso = solto = estavel = 0, press_count = 0 throughout.
- Defaults; botao rises cleanly before E0 and stays high -> pulso = 1 only in the cycle after E11, estavel = 1 from E11, press_count = 1. Then botao low -> solto = 1 for exactly one cycle, 11 edges after first low sample, estavel = 0.
- Bounce: botao high for 9 samples, low 1, high 9, low 1, then steady high -> pulso asserts exactly once, 10 samples after the final rise; press_count = 1.
- 17 clean press/release cycles (NBITS_COUNT = 4) -> 17 pulso strobes, 17 solto strobes, press_count ends at 1 (wrapped past 15).
- Reset asserted asynchronously (between edges) at sample 6 of a press confirmation, released 3 cycles later with botao still high -> no pulso during or before the reset. After deassert, pulso fires 11 edges after the first post-reset edge. press_count = 1.
- Held button for 100 cycles -> exactly one pulso, estavel = 1 constant, no solto.
